sub_serial_ctrl: RTL and testbench

Sequential multi-byte subtraction controller for the ALU subtract path. It accepts two unsigned operands of NBYTES bytes, then drives one shared 8-bit borrow-chained subtract slice once per clock, least-significant byte first. Each stage's borrow-out is registered into the next stage's borrow-in. It then reports the difference, the final borrow and a zero flag with a done pulse. It sits between the ALU operation decoder and the byte subtractor, so wide subtractions reuse a single 8-bit datapath.

---
 rtl/sub_serial_ctrl_pkg.sv | 12 +
 rtl/sub_serial_ctrl_if.sv | 28 ++
 rtl/sub_serial_ctrl_byte_sub.sv | 43 ++++
 rtl/sub_serial_ctrl.sv | 133 +++++++++++++
 tb/tb_sub_serial_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/sub_serial_ctrl_pkg.sv
// Shared definitions for the serial multi-byte subtract controller.
package sub_serial_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_serial_ctrl_if.sv
// Request/result bundle between the ALU decoder (master) and the
// serial subtract controller (slave).
interface sub_serial_ctrl_if
  import sub_serial_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
);

  logic                     start;
  logic [BYTE_W*NBYTES-1:0] a;
  logic [BYTE_W*NBYTES-1:0] b;
  logic                     busy;
  logic                     done;
  logic [BYTE_W*NBYTES-1:0] diff;
  logic                     borrow;
  logic                     zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, zero
  );

endinterface

// File: rtl/sub_serial_ctrl_byte_sub.sv
// 8-bit borrow-chained subtract slice built from full-subtractor cells.
// Bit 0 is a full cell too so the incoming borrow is honoured.

module full_sub (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

module byte_sub
  import sub_serial_ctrl_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              bin,
  output logic [BYTE_W-1:0] d,
  output logic              bout
);

  logic [BYTE_W:0] chain;

  assign chain[0] = bin;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
    full_sub u_fs (
      .x  (a[i]),
      .y  (b[i]),
      .bi (chain[i]),
      .d  (d[i]),
      .bo (chain[i+1])
    );
  end

  assign bout = chain[BYTE_W];

endmodule

// File: rtl/sub_serial_ctrl.sv
// Serial multi-byte subtractor controller: walks one shared byte_sub slice
// across the operands, LSB first, carrying the borrow in a flop.
module sub_serial_ctrl
  import sub_serial_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sub_serial_ctrl_if.slave  bus
);

  localparam int         W        = BYTE_W * NBYTES;
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          idx;
  logic                bin;
  logic [W-1:0]        op_a;
  logic [W-1:0]        op_b;
  logic [W-1:0]        diff_q;
  logic                borrow_q;
  logic                zero_q;
  logic                busy_q;
  logic                done_q;
  logic [BYTE_W-1:0]   a_byte;
  logic [BYTE_W-1:0]   b_byte;
  logic [BYTE_W-1:0]   d_byte;
  logic                bout;
  logic                accept;
  logic                last_byte;

  assign accept    = (state == ST_IDLE) && bus.start;
  assign last_byte = (idx == LAST_IDX);

  // Select the operand bytes for the current index.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == 3'(i)) begin
        a_byte = op_a[i*BYTE_W +: BYTE_W];
        b_byte = op_b[i*BYTE_W +: BYTE_W];
      end
    end
  end

  byte_sub u_byte_sub (
    .a    (a_byte),
    .b    (b_byte),
    .bin  (bin),
    .d    (d_byte),
    .bout (bout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN:  if (last_byte) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand latch, byte walk, borrow flop and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      bin      <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a     <= bus.a;
            op_b     <= bus.b;
            idx      <= '0;
            bin      <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (idx == 3'(i)) diff_q[i*BYTE_W +: BYTE_W] <= d_byte;
          end
          bin <= bout;
          if (!last_byte) idx <= idx + 3'd1;
        end
        ST_DONE: begin
          zero_q   <= (diff_q == '0);
          borrow_q <= bin;
        end
        default: ;
      endcase
    end
  end

  // busy and done trail the FSM by one edge so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state == ST_RUN);
      done_q <= (state == ST_DONE);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_sub_serial_ctrl.sv
// Directed bench for sub_serial_ctrl: a 4-byte and a 1-byte instance.
module tb_sub_serial_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sub_serial_ctrl_if #(.NBYTES(4)) bus4 ();
  sub_serial_ctrl_if #(.NBYTES(1)) bus1 ();

  sub_serial_ctrl #(.NBYTES(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  sub_serial_ctrl #(.NBYTES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input bit one);
    return one ? bus1.busy : bus4.busy;
  endfunction

  function automatic logic done_of(input bit one);
    return one ? bus1.done : bus4.done;
  endfunction

  function automatic logic [31:0] diff_of(input bit one);
    return one ? {24'h0, bus1.diff} : bus4.diff;
  endfunction

  function automatic logic borrow_of(input bit one);
    return one ? bus1.borrow : bus4.borrow;
  endfunction

  function automatic logic zero_of(input bit one);
    return one ? bus1.zero : bus4.zero;
  endfunction

  // One full operation: done expected after edge k+N+1, busy for N cycles.
  task automatic run_op(input bit one, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ediff, input logic eb, input logic ez,
                        input string tag);
    int  nb;
    int  busy_cnt;
    int  cyc;
    bit  seen;
    nb       = one ? 1 : 4;
    busy_cnt = 0;
    cyc      = 0;
    seen     = 1'b0;
    @(negedge clk);
    if (one) begin
      bus1.a = av[7:0]; bus1.b = bv[7:0]; bus1.start = 1'b1;
    end else begin
      bus4.a = av; bus4.b = bv; bus4.start = 1'b1;
    end
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus4.start = 1'b0;
    chk({tag, "_clr"}, {31'h0, zero_of(one)} | {31'h0, borrow_of(one)} | {32'h0, diff_of(one)}, 64'h0);
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(posedge clk); #1;
      if (busy_of(one)) busy_cnt++;
      if (done_of(one)) begin
        seen = 1'b1;
        cyc  = i;
        chk({tag, "_busy_in_done"}, busy_of(one), 1'b0);
      end
    end
    chk({tag, "_lat"}, cyc, nb + 1);
    chk({tag, "_busycnt"}, busy_cnt, nb);
    chk({tag, "_diff"}, diff_of(one), ediff);
    chk({tag, "_borrow"}, borrow_of(one), eb);
    chk({tag, "_zero"}, zero_of(one), ez);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done_of(one), 1'b0);
  endtask

  initial begin
    int done_cnt;
    logic [31:0] diff_at_done;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus4.busy, 1'b0);
    chk("rst_done", bus4.done, 1'b0);
    chk("rst_diff", bus4.diff, 32'h0);
    chk("rst_borrow", bus4.borrow, 1'b0);
    chk("rst_zero", bus4.zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, "basic");
    run_op(0, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, "ripple");
    run_op(0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, "wrap");
    run_op(0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, "equal");
    run_op(0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "msb");
    run_op(0, 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, "ripple16");

    // start during RUN with new operands must be ignored.
    @(negedge clk);
    bus4.a = 32'h0000_0005; bus4.b = 32'h0000_0003; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    bus4.a = 32'hFFFF_0000; bus4.b = 32'h0000_0001;
    @(posedge clk); #1;
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    done_cnt = 0;
    diff_at_done = '0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (bus4.done) begin
        done_cnt++;
        diff_at_done = bus4.diff;
      end
    end
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_diff", diff_at_done, 32'h0000_0002);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus4.a = 32'h0000_0100; bus4.b = 32'h0000_0001; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_busy", bus4.busy, 1'b1);
    chk("mid_diff", bus4.diff, 32'h0000_00FF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus4.busy, 1'b0);
    chk("arst_diff", bus4.diff, 32'h0);
    chk("arst_done", bus4.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus4.done || bus4.busy) done_cnt++;
    end
    chk("arst_quiet", done_cnt, 0);
    run_op(0, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, "post_rst");

    run_op(1, 32'h10, 32'h20, 32'hF0, 1'b1, 1'b0, "n1_borrow");
    run_op(1, 32'h7F, 32'h7F, 32'h00, 1'b0, 1'b1, "n1_equal");
    run_op(1, 32'hFF, 32'h01, 32'hFE, 1'b0, 1'b0, "n1_plain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
